// File: rtl/iter_muldiv.sv
// iter_muldiv: iterative 32-bit shift-add multiplier / restoring divider writing one result into the register file.
// Optional feature macro MULDIV_SIGNED_EN: when defined, op[2]=1 selects signed two's-complement operation.
module iter_muldiv #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [2:0]            op,
  input  logic [DATA_WIDTH-1:0] src_a,
  input  logic [DATA_WIDTH-1:0] src_b,
  input  logic [ADDR_WIDTH-1:0] dest,
  output logic                  busy,
  output logic                  done,
  output logic                  wen,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [DATA_WIDTH-1:0] wdata
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIX = 2'd2, DONE = 2'd3} state_t;

  state_t                  state;
  logic [1:0]              kind;
  logic [4:0]              count;
  logic [DATA_WIDTH-1:0]   opnd;
  logic [DATA_WIDTH-1:0]   hi;
  logic [DATA_WIDTH-1:0]   lo;
  logic [DATA_WIDTH-1:0]   mag_a;
  logic [DATA_WIDTH-1:0]   mag_b;
  logic [DATA_WIDTH:0]     mul_sum;
  logic [2*DATA_WIDTH-1:0] mul_shift;
  logic [DATA_WIDTH:0]     div_shift;
  logic [DATA_WIDTH:0]     div_diff;
  logic [DATA_WIDTH-1:0]   hi_next;
  logic [DATA_WIDTH-1:0]   lo_next;
  logic [2*DATA_WIDTH-1:0] prod;
  logic [DATA_WIDTH-1:0]   quo;
  logic [DATA_WIDTH-1:0]   rem;
  logic [DATA_WIDTH-1:0]   result;
`ifdef MULDIV_SIGNED_EN
  logic                    neg_a;
  logic                    neg_b;
`else
  logic                    unused_sign;
`endif

  // Operand magnitudes presented at acceptance.
  always_comb begin
`ifdef MULDIV_SIGNED_EN
    if (op[2] && src_a[DATA_WIDTH-1]) mag_a = -src_a;
    else                              mag_a = src_a;
    if (op[2] && src_b[DATA_WIDTH-1]) mag_b = -src_b;
    else                              mag_b = src_b;
`else
    mag_a       = src_a;
    mag_b       = src_b;
    unused_sign = op[2];
`endif
  end

  // One radix-2 step: hi/lo hold product halves for multiply, remainder/quotient for divide.
  always_comb begin
    mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : {(DATA_WIDTH+1){1'b0}});
    mul_shift = {mul_sum, lo[DATA_WIDTH-1:1]};
    div_shift = {hi, lo[DATA_WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd};
    if (!kind[1]) begin
      hi_next = mul_shift[2*DATA_WIDTH-1:DATA_WIDTH];
      lo_next = mul_shift[DATA_WIDTH-1:0];
    end else if (!div_diff[DATA_WIDTH]) begin
      hi_next = div_diff[DATA_WIDTH-1:0];
      lo_next = {lo[DATA_WIDTH-2:0], 1'b1};
    end else begin
      hi_next = div_shift[DATA_WIDTH-1:0];
      lo_next = {lo[DATA_WIDTH-2:0], 1'b0};
    end
  end

  // Sign correction and result-half selection; remainder follows the dividend's sign.
  always_comb begin
    prod = {hi, lo};
    quo  = lo;
    rem  = hi;
`ifdef MULDIV_SIGNED_EN
    if (neg_a ^ neg_b) begin
      prod = -{hi, lo};
      quo  = -lo;
    end else begin
      prod = {hi, lo};
      quo  = lo;
    end
    if (neg_a) rem = -hi;
    else       rem = hi;
`endif
    case (kind)
      2'b00:   result = prod[DATA_WIDTH-1:0];
      2'b01:   result = prod[2*DATA_WIDTH-1:DATA_WIDTH];
      2'b10:   result = quo;
      default: result = rem;
    endcase
  end

  // Control FSM, datapath registers and registered write-port outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      kind  <= 2'b00;
      count <= 5'd0;
      opnd  <= '0;
      hi    <= '0;
      lo    <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      wen   <= 1'b0;
      waddr <= '0;
      wdata <= '0;
`ifdef MULDIV_SIGNED_EN
      neg_a <= 1'b0;
      neg_b <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          wen  <= 1'b0;
          if (start) begin
            state <= RUN;
            busy  <= 1'b1;
            kind  <= op[1:0];
            waddr <= dest;
            count <= 5'd0;
            hi    <= '0;
            if (!op[1]) begin
              opnd <= mag_a;
              lo   <= mag_b;
            end else begin
              opnd <= mag_b;
              lo   <= mag_a;
            end
`ifdef MULDIV_SIGNED_EN
            neg_a <= op[2] & src_a[DATA_WIDTH-1];
            neg_b <= op[2] & src_b[DATA_WIDTH-1];
`endif
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        RUN: begin
          hi    <= hi_next;
          lo    <= lo_next;
          count <= count + 5'd1;
          if (count == 5'd31) state <= FIX;
          else                state <= RUN;
        end
        FIX: begin
          wdata <= result;
          done  <= 1'b1;
          wen   <= (waddr != '0);
          busy  <= 1'b0;
          state <= DONE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
